// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and unified-memory signals shared by the arbiter and its environment.
// A request is held with its payload stable until the matching *_gnt is seen; rvalid follows a grant by one cycle.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic        mem_unsigned_access;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_data_in, mem_read_write, mem_access_size, mem_unsigned_access
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_data_in, mem_read_write, mem_access_size, mem_unsigned_access
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified byte-addressed memory between instruction fetch and load/store,
// with a starvation counter that eventually lets fetch win and registered, fault-checked responses.
module mem_port_arbiter #(
    parameter int unsigned MEM_BYTES    = 64*1024*1024,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int         CW           = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic [CW-1:0]     starve_cnt
);

    localparam logic [32:0]   MEM_END = 33'(MEM_BYTES);
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

    logic        if_err_c;
    logic        d_err_c;
    logic        if_pri;
    logic        if_gnt_c;
    logic        d_gnt_c;
    logic [32:0] if_end;
    logic [32:0] d_end;
    logic [32:0] d_bytes;
    logic        if_rvalid_q;
    logic        d_rvalid_q;

    // End addresses are computed one bit wider so accesses near 2^32 cannot wrap past the range check.
    always_comb begin
        if_end = {1'b0, bus.if_addr} + 33'd4;
        case (bus.d_size)
            2'b00:   d_bytes = 33'd1;
            2'b01:   d_bytes = 33'd2;
            default: d_bytes = 33'd4;
        endcase
        d_end = {1'b0, bus.d_addr} + d_bytes;

        if_err_c = (bus.if_addr[1:0] != 2'b00) || (if_end > MEM_END);
        d_err_c  = (bus.d_size == 2'b11)
                || ((bus.d_size == 2'b01) && bus.d_addr[0])
                || ((bus.d_size == 2'b10) && (bus.d_addr[1:0] != 2'b00))
                || (d_end > MEM_END);
    end

    always_comb begin
        if_pri   = (starve_cnt >= LIMIT);
        if_gnt_c = !reset && bus.if_req && (!bus.d_req || if_pri);
        d_gnt_c  = !reset && bus.d_req && !if_gnt_c;
    end

    assign bus.if_gnt = if_gnt_c;
    assign bus.d_gnt  = d_gnt_c;

    // Faulting or idle cycles park the memory on a harmless word read of address 0.
    always_comb begin
        bus.mem_address         = 32'h0;
        bus.mem_data_in         = 32'h0;
        bus.mem_read_write      = 1'b1;
        bus.mem_access_size     = 2'b10;
        bus.mem_unsigned_access = 1'b1;
        if (if_gnt_c && !if_err_c) begin
            bus.mem_address = bus.if_addr;
        end else if (d_gnt_c && !d_err_c) begin
            bus.mem_address         = bus.d_addr;
            bus.mem_data_in         = bus.d_wdata;
            bus.mem_read_write      = ~bus.d_we;
            bus.mem_access_size     = bus.d_size;
            bus.mem_unsigned_access = bus.d_unsigned;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_rvalid_q  <= 1'b0;
            bus.if_err   <= 1'b0;
            bus.if_rdata <= 32'h0;
            d_rvalid_q   <= 1'b0;
            bus.d_err    <= 1'b0;
            bus.d_rdata  <= 32'h0;
        end else begin
            if_rvalid_q  <= if_gnt_c;
            bus.if_err   <= if_gnt_c && if_err_c;
            bus.if_rdata <= (if_gnt_c && !if_err_c) ? bus.mem_data_out : 32'h0;
            d_rvalid_q   <= d_gnt_c;
            bus.d_err    <= d_gnt_c && d_err_c;
            bus.d_rdata  <= (d_gnt_c && !d_err_c && !bus.d_we) ? bus.mem_data_out : 32'h0;
        end
    end

    // A response whose valid cycle coincides with reset is withdrawn immediately.
    assign bus.if_rvalid = if_rvalid_q && !reset;
    assign bus.d_rvalid  = d_rvalid_q && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt_c || !bus.if_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a byte-level reference memory
// and a rule-based arbitration model.
module tb_mem_port_arbiter;
    localparam int unsigned MEM_BYTES    = 64*1024*1024;
    localparam int unsigned STARVE_LIMIT = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] starve_cnt;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset), .bus(bus), .starve_cnt(starve_cnt)
    );

    // Physical memory seen by the DUT (word array) and independent reference memory (bytes).
    logic [31:0] mem_w [logic [29:0]];
    logic [7:0]  ref_b [logic [31:0]];
    logic [32:0] if_exp_q [$];
    logic [32:0] d_exp_q [$];
    int          model_cnt = 0;
    bit          last_if_gnt, last_d_gnt;
    logic        act_if_gnt, act_d_gnt, act_rw;

    function automatic bit access_err(logic [31:0] a, logic [1:0] sz);
        longint unsigned nb, aa;
        nb = 64'd1 << sz;
        aa = 64'(a);
        if (sz == 2'b11) return 1'b1;
        if ((aa % nb) != 0) return 1'b1;
        return (aa + nb) > 64'(MEM_BYTES);
    endfunction

    function automatic logic [7:0] ref_byte(logic [31:0] a);
        return ref_b.exists(a) ? ref_b[a] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, logic uns);
        longint unsigned v;
        int nb;
        nb = 1 << sz;
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (64'(ref_byte(a + 32'(i))) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * nb));
        return v[31:0];
    endfunction

    task automatic ref_store(logic [31:0] a, logic [31:0] data, logic [1:0] sz);
        for (int i = 0; i < (1 << sz); i++) ref_b[a + 32'(i)] = data[8*i +: 8];
    endtask

    function automatic logic [31:0] size_mask(logic [1:0] sz);
        case (sz)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] phys_read(logic [31:0] a, logic [1:0] sz, logic uns);
        logic [31:0] w, m;
        w = mem_w.exists(a[31:2]) ? mem_w[a[31:2]] : 32'h0;
        m = size_mask(sz);
        w = (w >> (8 * int'(a[1:0]))) & m;
        if (!uns && ((w & m & ~(m >> 1)) != 0)) w = w | ~m;
        return w;
    endfunction

    task automatic phys_write(logic [31:0] a, logic [31:0] data, logic [1:0] sz);
        logic [31:0] w, m;
        int sh;
        w  = mem_w.exists(a[31:2]) ? mem_w[a[31:2]] : 32'h0;
        m  = size_mask(sz);
        sh = 8 * int'(a[1:0]);
        mem_w[a[31:2]] = (w & ~(m << sh)) | ((data & m) << sh);
    endtask

    task automatic preload(logic [31:0] a, logic [31:0] data);
        phys_write(a, data, 2'b10);
        ref_store(a, data, 2'b10);
    endtask

    task automatic drive_if(logic req, logic [31:0] a);
        bus.if_req  = req;
        bus.if_addr = a;
    endtask

    task automatic drive_d(logic req, logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz, logic uns);
        bus.d_req      = req;
        bus.d_we       = we;
        bus.d_addr     = a;
        bus.d_wdata    = wd;
        bus.d_size     = sz;
        bus.d_unsigned = uns;
    endtask

    // One clock cycle: check the responses of the previous grant, this cycle's grant and memory drive,
    // update the reference model, then let the memory commit any write at the edge.
    task automatic step();
        bit eg_if, eg_d, e_err_if, e_err_d, exp_v, chk_wd, wr;
        logic [32:0] e;
        logic [31:0] e_addr, e_wd, w_addr, w_data;
        logic [1:0]  e_sz, w_sz;
        logic        e_un, e_rw;
        #1;
        if (reset) begin
            n_checks++;
            if ({bus.if_rvalid, bus.d_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL rvalid_in_reset got=%b want=00", {bus.if_rvalid, bus.d_rvalid});
            end
            if_exp_q.delete();
            d_exp_q.delete();
        end else begin
            exp_v = if_exp_q.size() != 0;
            n_checks++;
            if (bus.if_rvalid !== exp_v) begin
                n_fail++; $display("FAIL if_rvalid got=%b want=%b t=%0t", bus.if_rvalid, exp_v, $time);
            end
            if (exp_v) begin
                e = if_exp_q.pop_front();
                n_checks++;
                if ({bus.if_err, bus.if_rdata} !== e) begin
                    n_fail++; $display("FAIL if_resp got=%h want=%h t=%0t", {bus.if_err, bus.if_rdata}, e, $time);
                end
            end
            exp_v = d_exp_q.size() != 0;
            n_checks++;
            if (bus.d_rvalid !== exp_v) begin
                n_fail++; $display("FAIL d_rvalid got=%b want=%b t=%0t", bus.d_rvalid, exp_v, $time);
            end
            if (exp_v) begin
                e = d_exp_q.pop_front();
                n_checks++;
                if ({bus.d_err, bus.d_rdata} !== e) begin
                    n_fail++; $display("FAIL d_resp got=%h want=%h t=%0t", {bus.d_err, bus.d_rdata}, e, $time);
                end
            end
        end
        n_checks++;
        if (starve_cnt !== 3'(model_cnt)) begin
            n_fail++; $display("FAIL starve_cnt got=%0d want=%0d t=%0t", starve_cnt, model_cnt, $time);
        end

        eg_if    = !reset && bus.if_req && (!bus.d_req || model_cnt >= int'(STARVE_LIMIT));
        eg_d     = !reset && bus.d_req && !eg_if;
        e_err_if = access_err(bus.if_addr, 2'b10);
        e_err_d  = access_err(bus.d_addr, bus.d_size);
        act_if_gnt = bus.if_gnt;
        act_d_gnt  = bus.d_gnt;
        act_rw     = bus.mem_read_write;
        n_checks++;
        if ({bus.if_gnt, bus.d_gnt} !== {eg_if, eg_d}) begin
            n_fail++; $display("FAIL gnt got=%b want=%b t=%0t", {bus.if_gnt, bus.d_gnt}, {eg_if, eg_d}, $time);
        end

        e_addr = 32'h0; e_wd = 32'h0; e_sz = 2'b10; e_un = 1'b1; e_rw = 1'b1; chk_wd = 1'b1;
        if (eg_if && !e_err_if) begin
            e_addr = bus.if_addr;
        end else if (eg_d && !e_err_d) begin
            e_addr = bus.d_addr; e_sz = bus.d_size; e_un = bus.d_unsigned; e_rw = !bus.d_we;
            if (bus.d_we) e_wd = bus.d_wdata;
            else chk_wd = 1'b0;
        end
        n_checks++;
        if ({bus.mem_address, bus.mem_access_size, bus.mem_unsigned_access, bus.mem_read_write} !== {e_addr, e_sz, e_un, e_rw}) begin
            n_fail++; $display("FAIL mem_drive got=%h/%b/%b/%b want=%h/%b/%b/%b t=%0t", bus.mem_address,
                bus.mem_access_size, bus.mem_unsigned_access, bus.mem_read_write, e_addr, e_sz, e_un, e_rw, $time);
        end
        if (chk_wd) begin
            n_checks++;
            if (bus.mem_data_in !== e_wd) begin
                n_fail++; $display("FAIL mem_data_in got=%h want=%h t=%0t", bus.mem_data_in, e_wd, $time);
            end
        end

        bus.mem_data_out = phys_read(bus.mem_address, bus.mem_access_size, bus.mem_unsigned_access);
        if (eg_if) if_exp_q.push_back({e_err_if, e_err_if ? 32'h0 : ref_load(bus.if_addr, 2'b10, 1'b1)});
        if (eg_d) begin
            d_exp_q.push_back({e_err_d, (e_err_d || bus.d_we) ? 32'h0 : ref_load(bus.d_addr, bus.d_size, bus.d_unsigned)});
            if (!e_err_d && bus.d_we) ref_store(bus.d_addr, bus.d_wdata, bus.d_size);
        end
        if (reset || eg_if || !bus.if_req) model_cnt = 0;
        else if (model_cnt < int'(STARVE_LIMIT)) model_cnt++;

        #1;
        wr = (bus.mem_read_write === 1'b0);
        w_addr = bus.mem_address; w_data = bus.mem_data_in; w_sz = bus.mem_access_size;
        @(posedge clock);
        if (wr) phys_write(w_addr, w_data, w_sz);
        #1;
        last_if_gnt = eg_if;
        last_d_gnt  = eg_d;
    endtask

    task automatic test_reset();
        drive_if(1'b1, 32'h0100_0000);
        drive_d(1'b1, 1'b1, 32'h0, 32'h1234_5678, 2'b10, 1'b0);
        bus.mem_data_out = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        n_checks++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=0000", {bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err});
        end
        n_checks++;
        if ({bus.if_rdata, bus.d_rdata, starve_cnt} !== 67'h0) begin
            n_fail++; $display("FAIL reset_data got=%h/%h/%0d want=0/0/0", bus.if_rdata, bus.d_rdata, starve_cnt);
        end
        n_checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_read_write} !== 3'b001) begin
            n_fail++; $display("FAIL reset_gnt got=%b want=001", {bus.if_gnt, bus.d_gnt, bus.mem_read_write});
        end
        reset = 1'b0;
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        model_cnt = 0;
        step();
    endtask

    task automatic test_if_fetch();
        preload(32'h0100_0000, 32'h0000_0013);
        drive_if(1'b1, 32'h0100_0000);
        step();
        n_checks++;
        if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b10, 32'h0000_0013}) begin
            n_fail++; $display("FAIL if_fetch got=%b%b %h want=10 00000013", bus.if_rvalid, bus.if_err, bus.if_rdata);
        end
        drive_if(1'b0, 32'h0);
        step();
    endtask

    task automatic test_store_load();
        drive_d(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0);
        step();
        drive_d(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
        step();
        n_checks++;
        if (bus.d_rdata !== 32'hFFFF_DEAD) begin
            n_fail++; $display("FAIL load_half_signed got=%h want=ffffdead", bus.d_rdata);
        end
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 1'b1);
        step();
        n_checks++;
        if (bus.d_rdata !== 32'h0000_00EF) begin
            n_fail++; $display("FAIL load_byte_unsigned got=%h want=000000ef", bus.d_rdata);
        end
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
    endtask

    task automatic test_starve();
        drive_if(1'b1, 32'h0100_0000);
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({act_if_gnt, act_d_gnt} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL starve_pattern i=%0d got=%b want=%b", i, {act_if_gnt, act_d_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
            end
            if (last_d_gnt) bus.d_addr = 32'h100 + 32'($urandom_range(0, 7) * 4);
        end
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        logic        wes [4];
        addrs = '{32'h102, 32'h100, MEM_BYTES - 2, MEM_BYTES};
        sizes = '{2'b10, 2'b11, 2'b10, 2'b00};
        wes   = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_d(1'b1, wes[i], addrs[i], 32'h5555_AAAA, sizes[i], 1'b0);
            step();
            n_checks++;
            if ({act_d_gnt, act_rw, bus.d_rvalid, bus.d_err} !== 4'b1111) begin
                n_fail++; $display("FAIL d_error i=%0d got=%b want=1111", i, {act_d_gnt, act_rw, bus.d_rvalid, bus.d_err});
            end
        end
        drive_d(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        step();
        n_checks++;
        if (bus.d_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL mem_unchanged got=%h want=deadbeef", bus.d_rdata);
        end
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        drive_if(1'b1, 32'h0100_0002);
        step();
        n_checks++;
        if ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL if_misaligned got=%b%b %h want=11 00000000", bus.if_rvalid, bus.if_err, bus.if_rdata);
        end
        drive_if(1'b1, 32'hFFFF_FFFC);
        step();
        drive_if(1'b0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid();
        drive_if(1'b1, 32'h0100_0000);
        drive_d(1'b1, 1'b1, 32'h180, 32'hCAFE_F00D, 2'b10, 1'b0);
        step();
        bus.d_wdata = 32'h0BAD_0BAD;
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({act_if_gnt, act_d_gnt, act_rw} !== 3'b001) begin
            n_fail++; $display("FAIL reset_mid_gnt got=%b want=001", {act_if_gnt, act_d_gnt, act_rw});
        end
        n_checks++;
        if ({bus.if_rvalid, bus.d_rvalid, starve_cnt} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid_after got=%b%b %0d want=00 0", bus.if_rvalid, bus.d_rvalid, starve_cnt);
        end
        reset = 1'b0;
        drive_if(1'b0, 32'h0);
        drive_d(1'b1, 1'b0, 32'h180, 32'h0, 2'b10, 1'b0);
        step();
        n_checks++;
        if (bus.d_rdata !== 32'h0BAD_0BAD) begin
            n_fail++; $display("FAIL reset_mid_nowrite got=%h want=0bad0bad", bus.d_rdata);
        end
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [8];
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            drive_d(1'b1, 1'b1, 32'h200 + 32'(i * 4), words[i], 2'b10, 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive_d(1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 2'b10, 1'b0);
            step();
            n_checks++;
            if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, words[i]}) begin
                n_fail++; $display("FAIL b2b_load i=%0d got=%b %h want=1 %h", i, bus.d_rvalid, bus.d_rdata, words[i]);
            end
        end
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        for (int n = 0; n < 300; n++) begin
            if (!bus.if_req || last_if_gnt) begin
                a = 32'h0100_0000 + 32'($urandom_range(0, 7) * 4);
                if ($urandom_range(0, 15) == 0) a = a + 32'd2;
                if ($urandom_range(0, 31) == 0) a = MEM_BYTES;
                drive_if(1'($urandom_range(0, 1)), a);
            end
            if (!bus.d_req || last_d_gnt) begin
                sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a = ($urandom_range(0, 15) == 0) ? MEM_BYTES - 32'($urandom_range(1, 8))
                                                 : 32'h0100_0000 + 32'($urandom_range(0, 31));
                drive_d(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
            end
            step();
        end
        drive_if(1'b0, 32'h0);
        drive_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_store_load();
        test_starve();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
